iter_div_unit: RTL and testbench
================================

Name: iter_div_unit

Overview:
- Parametrised multi-cycle integer divider for the execute stage of the pipelined LoongArch core.
- Serves div.w/div.wu/mod.w/mod.wu and produces quotient and remainder in one operation.
- Uses restoring division at one quotient bit per cycle.
- Has a valid/ready handshake on both sides and a cancel input for pipeline flush.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values ≥ 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- div_valid  input  1  request valid
- div_ready  output  1  unit idle, can accept a request
- div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned
- div_src1  input  WIDTH  dividend
- div_src2  input  WIDTH  divisor
- cancel  input  1  flush; abort any operation in flight
- res_valid  output  1  result valid
- res_ready  input  1  consumer takes result
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder
- div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Reset is synchronous and active-high on clk.
  - State goes to IDLE; iteration counter = 0.
  - res_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - div_ready = 1 from the first cycle after reset deasserts.
- State machine: IDLE, BUSY, DONE. div_ready = (state == IDLE); res_valid = (state == DONE).
- IDLE: accept on div_valid & div_ready at edge k.
  - Latch |src1|, |src2|, and the sign of each operand (signs forced 0 when div_signed = 0).
  - Latch the zero-divisor flag.
  - Load counter = WIDTH, clear the partial remainder, go to BUSY.
- BUSY: each edge performs one restoring step.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - If non-negative, keep the difference and set quotient bit = 1; else quotient bit = 0.
  - Decrement the counter. The edge where the counter is 1 performs the last step and goes to DONE.
- Latency: steps occur at edges k+1 … k+WIDTH. res_valid is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accept cycle.
- quotient, remainder and div_by_zero are registered and written on entry to DONE. They hold until the next result is written.
- Sign fix-up on entry to DONE:
  - Quotient is negated if the dividend and divisor signs differ (truncation toward zero).
  - Remainder is negated if the dividend is negative (remainder takes the dividend's sign).
- Signed overflow: MIN / −1 gives quotient = MIN, remainder = 0. This falls out of the algorithm and needs no special path.
- Divide by zero, signed or unsigned: quotient = all ones, remainder = raw div_src1, div_by_zero = 1. No sign fix-up is applied.
- DONE: res_valid & data hold stable while res_ready = 0.
  - res_ready = 1 → IDLE at that edge.
  - A new request is accepted no earlier than the following cycle; there is no same-cycle re-issue.
- cancel = 1 in any state → IDLE at the next edge.
  - Counter cleared; res_valid = 0 next cycle.
  - Output data registers are left unchanged.
  - cancel has priority over acceptance and over the result handshake.
  - A request presented in the same cycle as cancel is not accepted.
- Inputs div_src1/div_src2/div_signed are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro: ITER_DIV_ZERO_FAST_EN.
- Defined: a request with div_src2 == 0 goes IDLE → DONE at the accept edge. res_valid is high in the next cycle with the divide-by-zero result values. The BUSY state is skipped.
- Undefined: a zero divisor takes the full WIDTH-cycle path. Result values are identical in both builds.

Test Plan:
- Unsigned 100 / 7 (WIDTH = 32) → quotient = 14, remainder = 2, div_by_zero = 0, res_valid exactly 32 cycles after the accept cycle.
- Signed 0xFFFFFFF9 (−7) / 2 → quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → quotient = 0x80000000, remainder = 0.
- Unsigned 5 / 0 → quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
  - Latency 32 cycles without ITER_DIV_ZERO_FAST_EN, 1 cycle with it.
- Accept 1000 / 3, assert cancel on the 10th BUSY cycle → res_valid never rises, div_ready = 1 the next cycle.
  - A following request of 9 / 3 → quotient = 3, remainder = 0.
- Backpressure and narrow width: hold res_ready = 0 for 5 cycles after res_valid → res_valid, quotient and remainder stay stable and div_ready stays 0.
  - Separately, a WIDTH = 8 instance computing unsigned 200 / 3 → quotient = 66, remainder = 2, latency 8 cycles.

Source files
------------

// File: rtl/iter_div_unit.sv
// Multi-cycle restoring integer divider (one quotient bit per cycle) with cancel and valid/ready handshakes.
// Optional build macro ITER_DIV_ZERO_FAST_EN: a zero divisor skips BUSY and reaches DONE at the accept edge.
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             cancel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshakes: a request transfers on an edge where div_valid && div_ready; a result transfers on an
  // edge where res_valid && res_ready. res_valid/data hold until taken; cancel overrides both.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] raw1_q, raw1_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_out_q, dbz_out_d;

  logic             sign1, sign2;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   shifted, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, dvd_step;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes; |MIN| is exactly representable as an unsigned WIDTH-bit value.
  always_comb begin
    sign1 = div_signed & div_src1[WIDTH-1];
    sign2 = div_signed & div_src2[WIDTH-1];
    abs1  = sign1 ? (~div_src1 + 1'b1) : div_src1;
    abs2  = sign2 ? (~div_src2 + 1'b1) : div_src2;
  end

  // One restoring step: shift {rem, dividend} left, trial-subtract the divisor in WIDTH+1 bits.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    qbit     = ~diff[WIDTH];
    rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step = {dvd_q[WIDTH-2:0], qbit};
    quo_fix  = neg_quo_q ? (~dvd_step + 1'b1) : dvd_step;
    rem_fix  = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    raw1_d    = raw1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;

    if (cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (div_valid) begin
            dvd_d     = abs1;
            dvs_d     = abs2;
            rem_d     = '0;
            raw1_d    = div_src1;
            neg_quo_d = sign1 ^ sign2;
            neg_rem_d = sign1;
            zero_d    = (div_src2 == '0);
            cnt_d     = CW'(WIDTH);
            state_d   = S_BUSY;
`ifdef ITER_DIV_ZERO_FAST_EN
            if (div_src2 == '0) begin
              cnt_d     = '0;
              quo_out_d = '1;
              rem_out_d = div_src1;
              dbz_out_d = 1'b1;
              state_d   = S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          dvd_d = dvd_step;
          rem_d = rem_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            if (zero_q) begin
              quo_out_d = '1;
              rem_out_d = raw1_q;
              dbz_out_d = 1'b1;
            end else begin
              quo_out_d = quo_fix;
              rem_out_d = rem_fix;
              dbz_out_d = 1'b0;
            end
          end
        end
        S_DONE: begin
          if (res_ready) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      raw1_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      raw1_q    <= raw1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign div_ready   = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: a WIDTH=32 instance plus a WIDTH=8 instance, scoreboard queues.
module tb_iter_div_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks = 0;
  int failures = 0;

`ifdef ITER_DIV_ZERO_FAST_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 32;
`endif

  // WIDTH = 32 instance
  logic        a_div_valid, a_div_ready, a_div_signed, a_cancel;
  logic [31:0] a_src1, a_src2, a_quotient, a_remainder;
  logic        a_res_valid, a_res_ready, a_dbz;
  logic [1:0]  a_state;

  iter_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .div_valid(a_div_valid), .div_ready(a_div_ready), .div_signed(a_div_signed),
    .div_src1(a_src1), .div_src2(a_src2), .cancel(a_cancel),
    .res_valid(a_res_valid), .res_ready(a_res_ready),
    .quotient(a_quotient), .remainder(a_remainder), .div_by_zero(a_dbz),
    .dbg_state(a_state)
  );

  // WIDTH = 8 instance
  logic       b_div_valid, b_div_ready, b_div_signed, b_cancel;
  logic [7:0] b_src1, b_src2, b_quotient, b_remainder;
  logic       b_res_valid, b_res_ready, b_dbz;
  logic [1:0] b_state;

  iter_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .div_valid(b_div_valid), .div_ready(b_div_ready), .div_signed(b_div_signed),
    .div_src1(b_src1), .div_src2(b_src2), .cancel(b_cancel),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .quotient(b_quotient), .remainder(b_remainder), .div_by_zero(b_dbz),
    .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  // entry = {div_by_zero, remainder, quotient}
  logic [64:0] exp_q[$];
  logic [16:0] exp8_q[$];
  logic [64:0] last_exp;

  task automatic push_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint sa, sb;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    exp_q.push_back({(b == 32'd0), r, q});
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!a_div_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    a_div_signed = sgn;
    a_src1 = a;
    a_src2 = b;
    a_div_valid = 1'b1;
    push_model(sgn, a, b);
    @(posedge clk); #1;
    a_div_valid = 1'b0;
    a_div_signed = 1'($urandom_range(0, 1));
    a_src1 = $urandom;
    a_src2 = $urandom;
  endtask

  task automatic await32(output int n);
    n = 0;
    while (!a_res_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic await8(output int n);
    n = 0;
    while (!b_res_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic consume32();
    a_res_ready = 1'b1;
    @(posedge clk); #1;
    a_res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (a_res_valid !== 1'b0 || a_quotient !== 32'd0 || a_remainder !== 32'd0 || a_dbz !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b q=%h r=%h dbz=%b, want 0/0/0/0",
               a_res_valid, a_quotient, a_remainder, a_dbz);
    end
    checks++;
    if (a_div_ready !== 1'b1 || b_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b/%b, want 1/1", a_div_ready, b_div_ready);
    end
    checks++;
    if (b_res_valid !== 1'b0 || b_quotient !== 8'd0 || b_remainder !== 8'd0 || b_dbz !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs8: got valid=%b q=%h r=%h dbz=%b, want 0", b_res_valid, b_quotient,
               b_remainder, b_dbz);
    end
  endtask

  task automatic test_divide();
    logic        sgn_t[10];
    logic [31:0] a_t[10];
    logic [31:0] b_t[10];
    logic [64:0] e;
    int n, exp_lat;
    sgn_t[0] = 0; a_t[0] = 32'd100;        b_t[0] = 32'd7;
    sgn_t[1] = 1; a_t[1] = 32'hFFFF_FFF9;  b_t[1] = 32'd2;
    sgn_t[2] = 1; a_t[2] = 32'h8000_0000;  b_t[2] = 32'hFFFF_FFFF;
    sgn_t[3] = 0; a_t[3] = 32'd5;          b_t[3] = 32'd0;
    sgn_t[4] = 1; a_t[4] = 32'hFFFF_FFF9;  b_t[4] = 32'd0;
    sgn_t[5] = 0; a_t[5] = 32'hFFFF_FFF9;  b_t[5] = 32'd2;
    for (int i = 6; i < 10; i++) begin
      sgn_t[i] = 1'($urandom_range(0, 1));
      a_t[i]   = $urandom;
      b_t[i]   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      issue32(sgn_t[i], a_t[i], b_t[i]);
      await32(n);
      exp_lat = (b_t[i] == 32'd0) ? ZLAT : 32;
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (n !== exp_lat) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d edges, want %0d", i, n, exp_lat);
      end
      checks++;
      if (a_quotient !== e[31:0] || a_remainder !== e[63:32] || a_dbz !== e[64]) begin
        failures++;
        $display("FAIL result[%0d] %h/%h s=%b: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b", i, a_t[i],
                 b_t[i], sgn_t[i], a_quotient, a_remainder, a_dbz, e[31:0], e[63:32], e[64]);
      end
      consume32();
      checks++;
      if (a_div_ready !== 1'b1 || a_res_valid !== 1'b0) begin
        failures++;
        $display("FAIL handoff[%0d]: got ready=%b valid=%b, want 1/0", i, a_div_ready, a_res_valid);
      end
    end
  endtask

  task automatic test_cancel();
    logic [64:0] e;
    bit seen;
    int n;
    // cancel has priority over a same-cycle request
    a_div_signed = 1'b0; a_src1 = 32'd50; a_src2 = 32'd5;
    a_div_valid = 1'b1; a_cancel = 1'b1;
    @(posedge clk); #1;
    a_div_valid = 1'b0; a_cancel = 1'b0;
    checks++;
    if (a_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL cancel_vs_accept: got ready=%b, want 1", a_div_ready);
    end
    issue32(1'b0, 32'd1000, 32'd3);
    void'(exp_q.pop_back());
    repeat (9) begin
      @(posedge clk); #1;
    end
    a_cancel = 1'b1;
    @(posedge clk); #1;
    a_cancel = 1'b0;
    checks++;
    if (a_div_ready !== 1'b1 || a_res_valid !== 1'b0) begin
      failures++;
      $display("FAIL cancel_idle: got ready=%b valid=%b, want 1/0", a_div_ready, a_res_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_res_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL cancel_no_result: got res_valid rose=1, want 0");
    end
    checks++;
    if (a_quotient !== last_exp[31:0] || a_remainder !== last_exp[63:32]) begin
      failures++;
      $display("FAIL cancel_data_held: got q=%h r=%h, want q=%h r=%h", a_quotient, a_remainder,
               last_exp[31:0], last_exp[63:32]);
    end
    issue32(1'b0, 32'd9, 32'd3);
    await32(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== 32 || a_quotient !== 32'd3 || a_remainder !== 32'd0 || e[31:0] !== 32'd3) begin
      failures++;
      $display("FAIL after_cancel: got lat=%0d q=%h r=%h, want lat=32 q=3 r=0", n, a_quotient, a_remainder);
    end
    consume32();
  endtask

  task automatic test_backpressure();
    logic [64:0] e;
    int n;
    issue32(1'b1, 32'hFFFF_CFC7, 32'd67);
    await32(n);
    e = exp_q.pop_front();
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL bp_latency: got %0d, want 32", n);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (a_res_valid !== 1'b1 || a_div_ready !== 1'b0 || a_quotient !== e[31:0] || a_remainder !== e[63:32]) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b q=%h r=%h, want 1/0 q=%h r=%h", c, a_res_valid,
                 a_div_ready, a_quotient, a_remainder, e[31:0], e[63:32]);
      end
    end
    consume32();
    checks++;
    if (a_res_valid !== 1'b0 || a_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0/1", a_res_valid, a_div_ready);
    end
  endtask

  task automatic test_narrow();
    logic        sgn_t[2];
    logic [7:0]  a_t[2];
    logic [7:0]  b_t[2];
    logic [16:0] e;
    int n;
    sgn_t[0] = 0; a_t[0] = 8'd200; b_t[0] = 8'd3;
    sgn_t[1] = 1; a_t[1] = 8'h80;  b_t[1] = 8'hFF;
    exp8_q.push_back({1'b0, 8'd2, 8'd66});
    exp8_q.push_back({1'b0, 8'd0, 8'h80});
    for (int i = 0; i < 2; i++) begin
      b_div_signed = sgn_t[i]; b_src1 = a_t[i]; b_src2 = b_t[i];
      b_div_valid = 1'b1;
      @(posedge clk); #1;
      b_div_valid = 1'b0;
      b_src1 = 8'($urandom);
      await8(n);
      e = exp8_q.pop_front();
      checks++;
      if (n !== 8 || b_quotient !== e[7:0] || b_remainder !== e[15:8] || b_dbz !== e[16]) begin
        failures++;
        $display("FAIL narrow[%0d]: got lat=%0d q=%h r=%h dbz=%b, want lat=8 q=%h r=%h dbz=%b", i, n,
                 b_quotient, b_remainder, b_dbz, e[7:0], e[15:8], e[16]);
      end
      b_res_ready = 1'b1;
      @(posedge clk); #1;
      b_res_ready = 1'b0;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    a_div_valid = 0; a_div_signed = 0; a_src1 = 0; a_src2 = 0; a_cancel = 0; a_res_ready = 0;
    b_div_valid = 0; b_div_signed = 0; b_src1 = 0; b_src2 = 0; b_cancel = 0; b_res_ready = 0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_divide();
    test_cancel();
    test_backpressure();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
